apb_completer_regfile: RTL
==========================

// Module: apb_completer_regfile
// PURPOSE
//  APB4 completer (slave) fronting a bank of NUM_REGS word-wide registers; pairs with our APB master on one psel line.
//  Inserts WAIT_CYCLES wait states and honours byte strobes. Flags illegal accesses with pslverr. Exposes register contents to local logic.
// PARAMETERS
//  DATA_WIDTH      32          data bus width, multiple of 8
//  ADDR_WIDTH      10          byte address width
//  BYTES_PER_WORD  DATA_WIDTH/8 strobe width
//  NUM_REGS        16          register count, word-aligned from address 0; index NUM_REGS-1 is read-only ID
//  WAIT_CYCLES     0           wait states per transfer, 0..15
//  ID_VALUE        'hA5B0_0001 constant returned by ID register
//  PRIV_ONLY       0           1: reject accesses with pprot[0]==0
// PORTS
//  pclk       in   1                        clock, all logic rising-edge
//  preset_n   in   1                        asynchronous active-low reset
//  psel       in   1                        completer select
//  penable    in   1                        access phase
//  pwrite     in   1                        1 write, 0 read
//  paddr      in   ADDR_WIDTH               byte address
//  pwdata     in   DATA_WIDTH               write data
//  pstrb      in   BYTES_PER_WORD           write byte enables
//  pprot      in   3                        protection; only bit 0 (privileged) is used
//  prdata     out  DATA_WIDTH               read data, valid while pready=1
//  pready     out  1                        transfer completes this cycle
//  pslverr    out  1                        error, valid while pready=1
//  regs_flat  out  NUM_REGS*DATA_WIDTH      register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  Reset (async, preset_n=0): all registers 0, state IDLE, wait counter 0, pready=0, pslverr=0, prdata=0; ID reg always reads ID_VALUE.
//  Outputs prdata/pready/pslverr are registered.
//  FSM states: IDLE, WAIT, DONE.
//   IDLE: on setup cycle (psel=1, penable=0), decode the access and load counter with WAIT_CYCLES.
//    If WAIT_CYCLES==0, go to DONE. Otherwise go to WAIT.
//   WAIT: counter decrements once per cycle while psel=1. On counter==1, go to DONE.
//   DONE: pready=1 for exactly one cycle, together with prdata/pslverr. Next state IDLE; pready=0 next cycle.
//  Latency: with setup at cycle T, pready=1 in cycle T+1+WAIT_CYCLES.
//  Write commit: at the DONE clock edge, only if psel & penable & pwrite & !error. Byte k updated only if pstrb[k]=1.
//  Read: prdata = selected register. On error, prdata=0. Outside DONE, prdata=0.
//  Decode: word index = paddr >> log2(BYTES_PER_WORD). Error (pslverr=1 in DONE) when any of:
//   - misaligned: paddr low bits !=0
//   - index >= NUM_REGS
//   - write to ID register
//   - PRIV_ONLY=1 and pprot[0]=0
//  An error suppresses the write entirely.
//  Back-to-back: setup may occur in the cycle after DONE (psel held, penable=0). No idle cycle is required.
//  psel drops during WAIT (protocol violation): return to IDLE, no pready, no write, no error.
//  Reset asserted mid-transfer: immediate return to reset values; pending write is discarded.
//  Read transfers ignore pstrb.
// TESTING
//  1. WAIT_CYCLES=0: write 0xDEADBEEF to 0x004 with pstrb=4'hF, then read 0x004.
//     -> pready one cycle after setup; read returns 0xDEADBEEF; pslverr=0.
//  2. Reg1=0xDEADBEEF; write 0x11223344 to 0x004 with pstrb=4'b0101.
//     -> reg1 reads 0xDE22BE44.
//  3. WAIT_CYCLES=3: read 0x000 with setup at cycle T.
//     -> pready=0 in cycles T+1..T+3, pready=1 in T+4 only.
//  4. Error cases:
//     - read 0x002 -> pslverr=1, prdata=0
//     - read 0x040 (NUM_REGS=16) -> pslverr=1
//     - write 0x03C -> pslverr=1, ID still reads 0xA5B00001
//  5. PRIV_ONLY=1: write 0x004 with pprot=3'b000 -> pslverr=1, reg1 unchanged; same write with pprot=3'b001 -> succeeds.
//  6. WAIT_CYCLES=3: drop preset_n during WAIT of a write to 0x008.
//     -> pready=0 immediately; reg2 reads 0 after reset; next transfer completes normally.

Source files
------------

// File: rtl/apb_completer_regfile.sv
// ---------------------------------------------------------------------------
// apb_completer_regfile
// APB4 completer serving a bank of NUM_REGS word-wide registers.
// - Word-aligned from address 0.
// - The top register (index NUM_REGS-1) is a read-only ID constant.
// - Inserts WAIT_CYCLES wait states before each completion.
// - Writes honour byte strobes.
// - Illegal accesses complete with pslverr and have no side effect.
//
// Ports
//   i_pclk, i_preset_n        clock (rising edge), async active-low reset
//   i_psel, i_penable         APB select / access phase
//   i_pwrite, i_paddr         direction, byte address
//   i_pwdata, i_pstrb         write data, write byte enables
//   i_pprot                   protection; bit 0 = privileged
//   o_prdata, o_pready        registered read data, transfer complete
//   o_pslverr                 registered error, valid with o_pready
//   o_regs_flat               all register contents, reg i at [i*DW +: DW]
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no transfer in flight; waiting for a setup cycle
// S_WAIT | counting wait states; abandons the transfer if psel drops
// S_DONE | pready/prdata/pslverr presented; write commits at this edge
// ---------------------------------------------------------------------------
module apb_completer_regfile #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    BYTES_PER_WORD = DATA_WIDTH / 8,
    parameter int                    NUM_REGS       = 16,
    parameter int                    WAIT_CYCLES    = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE       = 'hA5B0_0001,
    parameter bit                    PRIV_ONLY      = 1'b0
) (
    input  logic                           i_pclk,
    input  logic                           i_preset_n,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic                           i_pwrite,
    input  logic [ADDR_WIDTH-1:0]          i_paddr,
    input  logic [DATA_WIDTH-1:0]          i_pwdata,
    input  logic [BYTES_PER_WORD-1:0]      i_pstrb,
    input  logic [2:0]                     i_pprot,
    output logic [DATA_WIDTH-1:0]          o_prdata,
    output logic                           o_pready,
    output logic                           o_pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs_flat
);

    localparam int                    ADDR_LSB = $clog2(BYTES_PER_WORD);
    localparam int                    IDX_W    = $clog2(NUM_REGS);
    localparam int                    CNT_W    = 4;
    localparam logic [CNT_W-1:0]      WC_LOAD  = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_WIDTH-1:0] NREGS_A  = ADDR_WIDTH'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ID_IDX_A = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_err;
    logic                  r_write;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS-1];
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

    logic                  w_setup;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic                  w_err_now;
    logic                  w_err_sel;
    logic                  w_write_sel;
    logic [IDX_W-1:0]      w_idx_sel;
    logic                  w_wr_en;
    logic                  w_pready_d;
    logic                  w_pslverr_d;
    logic [DATA_WIDTH-1:0] w_prdata_d;
    logic                  w_unused_ok;

    assign w_unused_ok = ^i_pprot[2:1];

    assign w_setup    = i_psel & ~i_penable;
    assign w_word_idx = i_paddr >> ADDR_LSB;
    assign w_err_now  = ((i_paddr & LSB_MASK) != '0)
                      | (w_word_idx >= NREGS_A)
                      | (i_pwrite && (w_word_idx == ID_IDX_A))
                      | (PRIV_ONLY && !i_pprot[0]);

    // With zero wait states the completion is decided in the setup cycle
    // itself, before the decode has been latched, so use the live decode.
    assign w_err_sel   = (r_state == S_IDLE) ? w_err_now : r_err;
    assign w_write_sel = (r_state == S_IDLE) ? i_pwrite : r_write;
    assign w_idx_sel   = (r_state == S_IDLE) ? w_word_idx[IDX_W-1:0] : r_idx;

    assign w_wr_en = (r_state == S_DONE) & i_psel & i_penable & i_pwrite & ~r_err;

    // ID register is a constant, not a flop.
    for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_regs
        assign w_regs[g] = r_regs[g];
    end
    assign w_regs[NUM_REGS-1] = ID_VALUE;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = w_regs[g];
    end

    // State register
    always_ff @(posedge i_pclk or negedge i_preset_n) begin
        if (!i_preset_n) r_state <= S_IDLE;
        else             r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_setup) w_next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (!i_psel)               w_next_state = S_IDLE;
                else if (r_wait_cnt == 1)  w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic, evaluated one cycle early so the outputs can be flopped
    always_comb begin
        w_pready_d  = (w_next_state == S_DONE);
        w_pslverr_d = w_pready_d & w_err_sel;
        w_prdata_d  = '0;
        if (w_pready_d && !w_err_sel && !w_write_sel) w_prdata_d = w_regs[w_idx_sel];
    end

    always_ff @(posedge i_pclk or negedge i_preset_n) begin
        if (!i_preset_n) begin
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_prdata  <= '0;
        end else begin
            o_pready  <= w_pready_d;
            o_pslverr <= w_pslverr_d;
            o_prdata  <= w_prdata_d;
        end
    end

    // Wait-state down-counter and decode capture at setup
    always_ff @(posedge i_pclk or negedge i_preset_n) begin
        if (!i_preset_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
            r_write    <= 1'b0;
            r_idx      <= '0;
        end else if (r_state == S_IDLE && w_setup) begin
            r_wait_cnt <= WC_LOAD;
            r_err      <= w_err_now;
            r_write    <= i_pwrite;
            r_idx      <= w_word_idx[IDX_W-1:0];
        end else if (r_state == S_WAIT && i_psel && r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    // Register bank with byte-strobe writes
    always_ff @(posedge i_pclk or negedge i_preset_n) begin
        if (!i_preset_n) begin
            for (int i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                for (int b = 0; b < BYTES_PER_WORD; b++) begin
                    if (r_idx == IDX_W'(i) && i_pstrb[b]) r_regs[i][8*b +: 8] <= i_pwdata[8*b +: 8];
                end
            end
        end
    end

endmodule
